// File: rtl/ifetch_buf_if.sv
// Fetch-unit bundle: instruction memory port, execute redirect and decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface ifetch_buf_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic               out_pred_taken;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, out_pred_taken,
    input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_pred_taken,
    output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_buf.sv
// Sequential fetch unit with a DEPTH-entry instruction queue and redirect/discard handling.
// Optional static JAL predecode is enabled by defining IFETCH_PREDECODE_EN.
module ifetch_buf #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         pc_rst_n,
  ifetch_buf_if.master bus
);
  localparam int         AW      = $clog2(DEPTH);
  localparam int         CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [PC_W-1:0]               fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]                 count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [AW-1:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
  logic                          run_q;
  logic [DEPTH-1:0][PC_W-1:0]    pc_mem_q;
  logic [DEPTH-1:0][INSTR_W-1:0] ins_mem_q;
  logic [DEPTH-1:0]              pred_mem_q;
  logic                          accept, rsp, keep, pop, int_redirect, pred;
  logic [PC_W-1:0]               redir_tgt, jal_tgt;

  assign redir_tgt = {bus.redirect_pc[PC_W-1:2], 2'b00};
  assign rsp       = bus.imem_rvalid;
  // A response in a redirect cycle is always stale, even with no discards pending.
  assign keep      = rsp & ~bus.redirect_valid & (discard_q == '0);
  assign pop       = bus.out_valid & bus.out_ready;

`ifdef IFETCH_PREDECODE_EN
  logic [20:0]     jimm;
  logic [PC_W-1:0] jsum;
  assign jimm = {bus.imem_rdata[31], bus.imem_rdata[19:12], bus.imem_rdata[20],
                 bus.imem_rdata[30:21], 1'b0};
  assign jsum = resp_pc_q + {{(PC_W-21){jimm[20]}}, jimm};
  assign jal_tgt      = {jsum[PC_W-1:2], 2'b00};
  assign pred         = (bus.imem_rdata[6:0] == 7'b1101111);
  assign int_redirect = keep & pred;
`else
  assign jal_tgt      = '0;
  assign pred         = 1'b0;
  assign int_redirect = 1'b0;
`endif

  // Credit: queued plus in-flight never exceeds DEPTH, so a kept response always fits.
  assign bus.imem_req = run_q & ~bus.redirect_valid & ~int_redirect &
                        (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C);
  assign bus.imem_addr      = fetch_pc_q;
  assign accept             = bus.imem_req & bus.imem_ready;
  assign bus.out_valid      = (count_q != '0);
  assign bus.out_pc         = pc_mem_q[rptr_q];
  assign bus.out_instr      = ins_mem_q[rptr_q];
  assign bus.out_pred_taken = pred_mem_q[rptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q + CW'(keep) - CW'(pop);
    inflight_d = inflight_q + CW'(accept) - CW'(rsp);
    discard_d  = discard_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (accept) fetch_pc_d = fetch_pc_q + PC_W'(4);
    if (keep) begin
      resp_pc_d = resp_pc_q + PC_W'(4);
      wptr_d    = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);
    if (bus.redirect_valid) begin
      fetch_pc_d = redir_tgt;
      resp_pc_d  = redir_tgt;
      count_d    = '0;
      rptr_d     = wptr_q;
      discard_d  = inflight_q - CW'(rsp);
    end else if (int_redirect) begin
      // JAL entry itself is pushed; everything fetched past it is stale.
      fetch_pc_d = jal_tgt;
      resp_pc_d  = jal_tgt;
      discard_d  = inflight_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      run_q      <= 1'b0;
      pc_mem_q   <= '0;
      ins_mem_q  <= '0;
      pred_mem_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      run_q      <= 1'b1;
      if (keep) begin
        pc_mem_q[wptr_q]   <= resp_pc_q;
        ins_mem_q[wptr_q]  <= bus.imem_rdata;
        pred_mem_q[wptr_q] <= pred;
      end
    end
  end
endmodule

// File: tb/tb_ifetch_buf.sv
// Randomized bench: in-order memory model plus a program-order model of what decode must see.
module tb_ifetch_buf;
  localparam int          PC_W     = 32;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] JAL_WORD = 32'h0200_006F; // jal x0, +0x20
`ifdef IFETCH_PREDECODE_EN
  localparam bit PD_EN = 1'b1;
`else
  localparam bit PD_EN = 1'b0;
`endif

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_buf_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
  ifetch_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .pc_rst_n(rst_n), .bus(bus));

  int          checks = 0, errors = 0;
  mreq_t       mq[$];
  logic [31:0] acc_log[$], pop_log[$];
  int          cyc = 0, n_acc = 0, n_pop = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100, ord_pct = 100, rsp_pct = 100;
  logic        redir_now = 1'b0, redir_on_jal = 1'b0, post_redir = 1'b0, jal_en = 1'b0;
  logic [31:0] redir_tgt = '0, exp_pc = '0, jal_addr = 32'h8;
  logic        s_req, s_acc, s_ovld, s_pop;
  logic [31:0] s_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_en && a == jal_addr) return JAL_WORD;
    return {a[26:2] ^ 25'h0F0_F0F0, 7'h13};
  endfunction

  function automatic logic is_jal(input logic [31:0] ins);
    return PD_EN && (ins[6:0] == 7'b1101111);
  endfunction

  // Program order: a predicted JAL continues at its target, anything else at pc+4.
  function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] imm;
    imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    if (is_jal(ins)) return (pc + imm) & ~32'h3;
    return pc + 32'd4;
  endfunction

  task automatic cycle();
    logic        rv;
    logic [31:0] ins;
    @(posedge clk); #1;
    cyc++;
    rv = (mq.size() > 0) && (mq[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(mq[0].addr) : 32'h0;
    if (redir_on_jal && rv && mq[0].addr == jal_addr) begin
      redir_now = 1'b1; redir_tgt = 32'h200; redir_on_jal = 1'b0;
    end
    bus.redirect_valid = redir_now;
    bus.redirect_pc    = redir_tgt;
    bus.imem_ready     = ($urandom_range(99) < rdy_pct);
    bus.out_ready      = ($urandom_range(99) < ord_pct);
    #1;
    if (post_redir) chk("vld_after_redir", bus.out_valid, 1'b0);
    post_redir = 1'b0;
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;
    s_ovld = bus.out_valid;
    s_acc  = s_req & bus.imem_ready;
    s_pop  = s_ovld & bus.out_ready;
    if (s_acc) begin
      chk("addr_align", s_addr[1:0], 2'b00);
      chk("credit", mq.size() < DEPTH, 1'b1);
      mq.push_back('{addr: s_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      acc_log.push_back(s_addr);
      n_acc++;
    end
    if (rv) void'(mq.pop_front());
    if (s_pop) begin
      ins = mem_word(exp_pc);
      chk("pop_pc", bus.out_pc, exp_pc);
      chk("pop_instr", bus.out_instr, ins);
      chk("pop_pred", bus.out_pred_taken, is_jal(ins));
      pop_log.push_back(bus.out_pc);
      exp_pc = next_pc(exp_pc, ins);
      n_pop++;
    end
    if (redir_now) begin
      exp_pc     = {redir_tgt[31:2], 2'b00};
      post_redir = 1'b1;
      redir_now  = 1'b0;
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redir_now = 1'b1;
    redir_tgt = tgt;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_acc, first_vld, base, bpop;
    logic saw8, saw200;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    #12;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_ovld", bus.out_valid, 1'b0);
    chk("rst_opc", bus.out_pc, 32'h0);
    chk("rst_oins", bus.out_instr, 32'h0);
    chk("rst_pred", bus.out_pred_taken, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; bus.imem_ready = 1'b1;
    #1;
    chk("req_before_run", bus.imem_req, 1'b0);

    // Fill with a 1-cycle memory and decode always ready.
    cycle();
    chk("first_req", s_req, 1'b1);
    chk("first_addr", s_addr, 32'h0);
    first_acc = s_acc ? cyc : -100;
    first_vld = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (first_vld < 0 && s_ovld) first_vld = cyc;
    end
    chk("fill_latency", 64'(first_vld - first_acc), 64'd2);
    chk("fill_rate", n_pop >= 15, 1'b1);

    // Decode stalled: exactly DEPTH fetches, then no loss on release.
    ord_pct = 0;
    redirect(32'h0);
    base = n_acc;
    for (int i = 0; i < 12; i++) cycle();
    chk("bp_accepts", 64'(n_acc - base), 64'(DEPTH));
    chk("bp_req_off", s_req, 1'b0);
    ord_pct = 100;
    bpop = pop_log.size();
    for (int i = 0; i < 12; i++) cycle();
    for (int i = 0; i < 5; i++) chk("bp_order", pop_log[bpop+i], 32'(4*i));

    // 3-cycle memory, redirect with 3 stale requests in flight, unaligned target.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq.size() < 3; i++) cycle();
    chk("inflight3", 64'(mq.size()), 64'd3);
    redirect(32'h103);
    cycle();
    chk("redir_req", s_req, 1'b1);
    chk("redir_addr", s_addr, 32'h100);
    bpop = pop_log.size();
    for (int i = 0; i < 15; i++) cycle();
    chk("redir_first_pc", pop_log[bpop], 32'h100);

    // Address wrap.
    lat_min = 1; lat_max = 1;
    redirect(32'hFFFF_FFF8);
    base = acc_log.size();
    for (int i = 0; i < 10; i++) cycle();
    chk("wrap_a0", acc_log[base],   32'hFFFF_FFF8);
    chk("wrap_a1", acc_log[base+1], 32'hFFFF_FFFC);
    chk("wrap_a2", acc_log[base+2], 32'h0);

    // JAL at 0x8 (+0x20).
    lat_min = 2; lat_max = 2;
    redirect(32'h0);
    jal_en = 1'b1;
    bpop = pop_log.size();
    for (int i = 0; i < 20; i++) cycle();
    chk("jal_pc", pop_log[bpop+2], 32'h8);
    chk("jal_next", pop_log[bpop+3], PD_EN ? 32'h28 : 32'hC);

    // Same JAL with an external redirect to 0x200 in its response cycle.
    redirect(32'h0);
    redir_on_jal = 1'b1;
    bpop = pop_log.size();
    for (int i = 0; i < 20; i++) cycle();
    chk("jal_ext_hit", redir_on_jal, 1'b0);
    saw8 = 1'b0; saw200 = 1'b0;
    for (int i = bpop; i < pop_log.size(); i++) begin
      if (pop_log[i] == 32'h8) saw8 = 1'b1;
      if (pop_log[i] == 32'h200) saw200 = 1'b1;
    end
    chk("jal_ext_dropped", saw8, 1'b0);
    chk("jal_ext_target", saw200, 1'b1);

    // Random traffic: variable latency, stalls on every side, random redirects.
    redirect(32'h40);
    jal_en = 1'b0;
    lat_min = 1; lat_max = 4; rdy_pct = 70; ord_pct = 60; rsp_pct = 80;
    base = n_pop;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_now = 1'b1;
        redir_tgt = 32'($urandom_range(32'hFFF));
      end
      cycle();
    end
    chk("rand_progress", (n_pop - base) > 300, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
